// File: rtl/axi4_lite_master_write.sv
// AXI4-Lite single-beat write initiator: one local request drives AW/W concurrently,
// then waits on B and reports completion with an error flag.
module axi4_lite_master_write #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic                          i_start_write,
  input  logic [AXI_ADDR_WIDTH-1:0]     i_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     i_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   i_strb,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  output logic                          AW_VALID,
  output logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR,
  output logic [2:0]                    AW_PROT,
  input  logic                          AW_READY,
  output logic                          W_VALID,
  output logic [AXI_DATA_WIDTH-1:0]     W_DATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   W_STRB,
  input  logic                          W_READY,
  input  logic                          B_VALID,
  input  logic [1:0]                    B_RESP,
  output logic                          B_READY
);

  typedef enum logic [1:0] {StIdle, StSend, StResp} state_e;

  state_e                        state_q, state_d;
  logic                          aw_valid_q, aw_valid_d;
  logic                          w_valid_q, w_valid_d;
  logic                          b_ready_q, b_ready_d;
  logic [AXI_ADDR_WIDTH-1:0]     aw_addr_q, aw_addr_d;
  logic [AXI_DATA_WIDTH-1:0]     w_data_q, w_data_d;
  logic [AXI_DATA_WIDTH/8-1:0]   w_strb_q, w_strb_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          error_q, error_d;
  logic                          aw_done_q, aw_done_d;
  logic                          w_done_q, w_done_d;

  logic aw_hs, w_hs, b_hs;

  assign aw_hs = aw_valid_q & AW_READY;
  assign w_hs  = w_valid_q & W_READY;
  assign b_hs  = B_VALID & b_ready_q;

  always_comb begin
    state_d    = state_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    busy_d     = busy_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    // Completion flags are single-cycle pulses.
    done_d     = 1'b0;
    error_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start_write) begin
          aw_addr_d  = i_addr;
          w_data_d   = i_data;
          w_strb_d   = i_strb;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          busy_d     = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (aw_hs) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_hs) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        // A handshake on this edge counts toward completion.
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          b_ready_d = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (b_hs) begin
          b_ready_d = 1'b0;
          done_d    = 1'b1;
          error_d   = |B_RESP;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= StIdle;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  assign AW_VALID = aw_valid_q;
  assign AW_ADDR  = aw_addr_q;
  assign AW_PROT  = 3'b000;
  assign W_VALID  = w_valid_q;
  assign W_DATA   = w_data_q;
  assign W_STRB   = w_strb_q;
  assign B_READY  = b_ready_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_error  = error_q;

endmodule

// File: tb/tb_axi4_lite_master_write.sv
// Directed bench for axi4_lite_master_write: table of write transactions with slave ready
// delays and response codes, plus hand sequences for busy-ignore, back-to-back and reset.
module tb_axi4_lite_master_write;

  logic        clk;
  logic        arstn;
  logic        i_start_write;
  logic [63:0] i_addr;
  logic [31:0] i_data;
  logic [3:0]  i_strb;
  logic        o_busy, o_done, o_error;
  logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
  logic [63:0] AW_ADDR;
  logic [2:0]  AW_PROT;
  logic [31:0] W_DATA;
  logic [3:0]  W_STRB;
  logic [1:0]  B_RESP;

  int checks = 0;
  int errors = 0;

  axi4_lite_master_write #(
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(32)
  ) dut (
    .clk          (clk),
    .arstn        (arstn),
    .i_start_write(i_start_write),
    .i_addr       (i_addr),
    .i_data       (i_data),
    .i_strb       (i_strb),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .AW_VALID     (AW_VALID),
    .AW_ADDR      (AW_ADDR),
    .AW_PROT      (AW_PROT),
    .AW_READY     (AW_READY),
    .W_VALID      (W_VALID),
    .W_DATA       (W_DATA),
    .W_STRB       (W_STRB),
    .W_READY      (W_READY),
    .B_VALID      (B_VALID),
    .B_RESP       (B_RESP),
    .B_READY      (B_READY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;   // edges AW_READY is held low after the start edge
    int          w_dly;
    bit          b_early;  // slave raises B_VALID before B_READY
    logic [1:0]  resp;
    bit          err;      // expected o_error
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_aw_valid"}, {63'd0, AW_VALID}, 64'd0);
    check({tag, "_w_valid"}, {63'd0, W_VALID}, 64'd0);
    check({tag, "_b_ready"}, {63'd0, B_READY}, 64'd0);
    check({tag, "_aw_addr"}, AW_ADDR, 64'd0);
    check({tag, "_w_data"}, {32'd0, W_DATA}, 64'd0);
    check({tag, "_w_strb"}, {60'd0, W_STRB}, 64'd0);
    check({tag, "_aw_prot"}, {61'd0, AW_PROT}, 64'd0);
    check({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
    check({tag, "_done"}, {63'd0, o_done}, 64'd0);
    check({tag, "_error"}, {63'd0, o_error}, 64'd0);
  endtask

  // Called on a negedge with the DUT idle; returns on a negedge one cycle after o_done.
  task automatic run_vec(input vec_t v, input int idx);
    int m;
    string t;
    t = $sformatf("v%0d", idx);
    m = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
    i_start_write = 1'b1;
    i_addr   = v.addr;
    i_data   = v.data;
    i_strb   = v.strb;
    AW_READY = 1'b0;
    W_READY  = 1'b0;
    B_VALID  = v.b_early;
    B_RESP   = v.resp;
    @(negedge clk);
    i_start_write = 1'b0;
    i_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    i_data = 32'hFFFF_FFFF;
    check({t, "_start_aw_valid"}, {63'd0, AW_VALID}, 64'd1);
    check({t, "_start_w_valid"}, {63'd0, W_VALID}, 64'd1);
    check({t, "_start_aw_addr"}, AW_ADDR, v.addr);
    check({t, "_start_w_data"}, {32'd0, W_DATA}, {32'd0, v.data});
    check({t, "_start_w_strb"}, {60'd0, W_STRB}, {60'd0, v.strb});
    check({t, "_start_busy"}, {63'd0, o_busy}, 64'd1);
    check({t, "_start_b_ready"}, {63'd0, B_READY}, 64'd0);
    for (int k = 1; k <= m + 2; k++) begin
      AW_READY = (k - 1 >= v.aw_dly);
      W_READY  = (k - 1 >= v.w_dly);
      B_VALID  = v.b_early || B_READY;
      @(negedge clk);
      check({t, "_aw_valid"}, {63'd0, AW_VALID}, {63'd0, k <= v.aw_dly});
      check({t, "_w_valid"}, {63'd0, W_VALID}, {63'd0, k <= v.w_dly});
      if (AW_VALID) check({t, "_aw_addr_hold"}, AW_ADDR, v.addr);
      if (W_VALID) begin
        check({t, "_w_data_hold"}, {32'd0, W_DATA}, {32'd0, v.data});
        check({t, "_w_strb_hold"}, {60'd0, W_STRB}, {60'd0, v.strb});
      end
      check({t, "_b_ready"}, {63'd0, B_READY}, {63'd0, k == m + 1});
      check({t, "_done"}, {63'd0, o_done}, {63'd0, k == m + 2});
      check({t, "_busy"}, {63'd0, o_busy}, {63'd0, k < m + 2});
      if (k == m + 2) check({t, "_error"}, {63'd0, o_error}, {63'd0, v.err});
    end
    B_VALID  = 1'b0;
    AW_READY = 1'b0;
    W_READY  = 1'b0;
    @(negedge clk);
    check({t, "_done_clear"}, {63'd0, o_done}, 64'd0);
    check({t, "_error_clear"}, {63'd0, o_error}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{64'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 1'b1, 2'b00, 1'b0};
    vecs[1] = '{64'h2000, 32'hCAFEF00D, 4'hF, 3, 0, 1'b0, 2'b00, 1'b0};
    vecs[2] = '{64'h2004, 32'h12345678, 4'h5, 0, 4, 1'b1, 2'b00, 1'b0};
    vecs[3] = '{64'h4000, 32'hA5A5A5A5, 4'h3, 0, 0, 1'b1, 2'b10, 1'b1};
    vecs[4] = '{64'hFFFF_0000_8000_0010, 32'h0BAD_F00D, 4'h8, 2, 2, 1'b0, 2'b01, 1'b1};
    vecs[5] = '{64'h4008, 32'h0000_0001, 4'h1, 1, 3, 1'b0, 2'b11, 1'b1};

    arstn = 1'b0;
    i_start_write = 1'b0;
    i_addr = '0;
    i_data = '0;
    i_strb = '0;
    AW_READY = 1'b0;
    W_READY  = 1'b0;
    B_VALID  = 1'b0;
    B_RESP   = 2'b00;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    arstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Busy request ignored, then back-to-back request in the o_done cycle.
    i_start_write = 1'b1;
    i_addr = 64'h5000;
    i_data = 32'h55AA55AA;
    i_strb = 4'hF;
    AW_READY = 1'b0;
    W_READY  = 1'b1;
    B_VALID  = 1'b1;
    B_RESP   = 2'b00;
    @(negedge clk);
    check("busy_first_addr", AW_ADDR, 64'h5000);
    i_addr = 64'h3000;
    @(negedge clk);
    i_start_write = 1'b0;
    check("busy_ignored_addr", AW_ADDR, 64'h5000);
    check("busy_aw_held", {63'd0, AW_VALID}, 64'd1);
    check("busy_w_done", {63'd0, W_VALID}, 64'd0);
    check("busy_no_b_ready", {63'd0, B_READY}, 64'd0);
    AW_READY = 1'b1;
    @(negedge clk);
    check("busy_b_ready", {63'd0, B_READY}, 64'd1);
    check("busy_no_done_yet", {63'd0, o_done}, 64'd0);
    @(negedge clk);
    check("busy_done", {63'd0, o_done}, 64'd1);
    check("busy_addr_after", AW_ADDR, 64'h5000);
    i_start_write = 1'b1;
    i_addr = 64'h6000;
    i_data = 32'h600D600D;
    @(negedge clk);
    i_start_write = 1'b0;
    check("b2b_single_done", {63'd0, o_done}, 64'd0);
    check("b2b_aw_valid", {63'd0, AW_VALID}, 64'd1);
    check("b2b_aw_addr", AW_ADDR, 64'h6000);
    check("b2b_w_data", {32'd0, W_DATA}, 64'h600D600D);
    @(negedge clk);
    check("b2b_b_ready", {63'd0, B_READY}, 64'd1);
    @(negedge clk);
    check("b2b_done", {63'd0, o_done}, 64'd1);
    B_VALID = 1'b0;
    AW_READY = 1'b0;
    W_READY = 1'b0;
    @(negedge clk);
    check("b2b_done_clear", {63'd0, o_done}, 64'd0);

    // Asynchronous reset while AW_VALID is high abandons the transaction.
    i_start_write = 1'b1;
    i_addr = 64'h7000;
    i_data = 32'h77777777;
    B_VALID = 1'b1;
    @(negedge clk);
    i_start_write = 1'b0;
    check("rst_pre_aw_valid", {63'd0, AW_VALID}, 64'd1);
    @(posedge clk);
    #3;
    arstn = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    arstn = 1'b1;
    AW_READY = 1'b1;
    W_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_no_done", {63'd0, o_done}, 64'd0);
      check("post_rst_idle", {63'd0, o_busy | AW_VALID | B_READY}, 64'd0);
    end
    B_VALID = 1'b0;
    run_vec(vecs[0], 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
